// File: rtl/seg7_result_display.sv
// Eight-digit common-anode hex display for the CPU result word.
// Shows dashes while the CPU runs; latches the word on the rising edge of iDone.
module seg7_result_display #(
   parameter int SCAN_DIV = 100000,
   parameter int DIGITS   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iDone,
   input  logic [31:0] iData,
   output logic [7:0]  oAnode,
   output logic [7:0]  oSeg,
   output logic        oValid
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]       LAST_DIGIT = 3'(DIGITS - 1);
   localparam logic [7:0]       SEG_DASH   = 8'hBF;

   typedef enum logic {IDLE, SHOW} state_t;

   state_t           state, stateNext;
   logic             doneQ;
   logic [DIV_W-1:0] divCnt, divNext;
   logic [2:0]       digit, digitNext;
   logic [31:0]      word, wordNext;
   logic             rise, fall;
   logic [3:0]       nibble;

   function automatic logic [7:0] hexSeg(input logic [3:0] v);
      case (v)
         4'h0: hexSeg = 8'hC0;
         4'h1: hexSeg = 8'hF9;
         4'h2: hexSeg = 8'hA4;
         4'h3: hexSeg = 8'hB0;
         4'h4: hexSeg = 8'h99;
         4'h5: hexSeg = 8'h92;
         4'h6: hexSeg = 8'h82;
         4'h7: hexSeg = 8'hF8;
         4'h8: hexSeg = 8'h80;
         4'h9: hexSeg = 8'h90;
         4'hA: hexSeg = 8'h88;
         4'hB: hexSeg = 8'h83;
         4'hC: hexSeg = 8'hC6;
         4'hD: hexSeg = 8'hA1;
         4'hE: hexSeg = 8'h86;
         default: hexSeg = 8'h8E;
      endcase
   endfunction

   always_comb begin
      rise      = iDone & ~doneQ;
      fall      = ~iDone & doneQ;
      stateNext = state;
      wordNext  = word;
      divNext   = divCnt;
      digitNext = digit;
      // Capture and release restart the scan at digit 0, overriding the divider.
      if (state == IDLE && rise) begin
         stateNext = SHOW;
         wordNext  = iData;
         divNext   = '0;
         digitNext = '0;
      end else if (state == SHOW && fall) begin
         stateNext = IDLE;
         divNext   = '0;
         digitNext = '0;
      end else if (divCnt == DIV_LAST) begin
         divNext   = '0;
         digitNext = (digit == LAST_DIGIT) ? 3'd0 : digit + 3'd1;
      end else begin
         divNext   = divCnt + 1'b1;
      end
      nibble = wordNext[{digitNext, 2'b00} +: 4];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         doneQ  <= 1'b0;
         divCnt <= '0;
         digit  <= '0;
         word   <= '0;
         oAnode <= 8'hFF;
         oSeg   <= 8'hFF;
         oValid <= 1'b0;
      end else begin
         state  <= stateNext;
         doneQ  <= iDone;
         divCnt <= divNext;
         digit  <= digitNext;
         word   <= wordNext;
         oAnode <= ~(8'b1 << digitNext);
         oSeg   <= (stateNext == SHOW) ? hexSeg(nibble) : SEG_DASH;
         oValid <= (stateNext == SHOW);
      end
   end

endmodule

// File: tb/tb_seg7_result_display.sv
// Bench for seg7_result_display: scenario tasks checked against a tick-count display model.
module tb_seg7_result_display;

   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        iDone;
   logic [31:0] iData;
   logic [7:0]  oAnode;
   logic [7:0]  oSeg;
   logic        oValid;

   int checks = 0;
   int errors = 0;

   logic [7:0] hexTab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   seg7_result_display #(.SCAN_DIV(SCAN_DIV), .DIGITS(8)) dut (
      .clk(clk), .rst(rst), .iDone(iDone), .iData(iData),
      .oAnode(oAnode), .oSeg(oSeg), .oValid(oValid)
   );

   always #5 clk = ~clk;

   // Model: the display position is just the number of scan ticks since the last
   // reset, capture or release; digit = (ticks / SCAN_DIV) mod 8.
   logic        mFresh, mShow, mPrev;
   logic [31:0] mWord;
   int          mTicks;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mFresh <= 1'b1; mShow <= 1'b0; mPrev <= 1'b0; mWord <= '0; mTicks <= 0;
      end else begin
         mFresh <= 1'b0;
         mPrev  <= iDone;
         if (!mShow && iDone && !mPrev) begin
            mShow <= 1'b1; mWord <= iData; mTicks <= 0;
         end else if (mShow && !iDone && mPrev) begin
            mShow <= 1'b0; mTicks <= 0;
         end else begin
            mTicks <= mTicks + 1;
         end
      end
   end

   function automatic int mDigit();
      return (mTicks / SCAN_DIV) % 8;
   endfunction

   function automatic logic [7:0] expAnode();
      if (mFresh) return 8'hFF;
      return ~(8'b1 << mDigit());
   endfunction

   function automatic logic [7:0] expSeg();
      logic [31:0] sh;
      if (mFresh) return 8'hFF;
      if (!mShow) return 8'hBF;
      sh = mWord >> (4 * mDigit());
      return hexTab[sh[3:0]];
   endfunction

   task automatic test_reset();
      rst = 1'b0; iDone = 1'b0; iData = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (oAnode !== 8'hFF || oSeg !== 8'hFF || oValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got anode=%h seg=%h valid=%b want FF FF 0", oAnode, oSeg, oValid);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (oAnode !== 8'hFE || oSeg !== 8'hBF || oValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got anode=%h seg=%h valid=%b want FE BF 0", oAnode, oSeg, oValid);
      end
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (oAnode !== expAnode() || oSeg !== expSeg() || oValid !== mShow) begin
            errors++;
            $display("FAIL idle_scan: got %h/%h/%b want %h/%h/%b", oAnode, oSeg, oValid, expAnode(), expSeg(), mShow);
         end
      end
   endtask

   task automatic test_capture();
      logic [7:0] seq [0:7] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
      iData = 32'h0123ABCD; iDone = 1'b1;
      @(negedge clk);
      checks++;
      if (oValid !== 1'b1 || oAnode !== 8'hFE || oSeg !== 8'hA1) begin
         errors++;
         $display("FAIL capture_first: got %h/%h/%b want FE/A1/1", oAnode, oSeg, oValid);
      end
      for (int k = 1; k <= 8; k++) begin
         repeat (SCAN_DIV) @(negedge clk);
         checks++;
         if (oSeg !== seq[k % 8] || oAnode !== ~(8'b1 << (k % 8)) || oValid !== 1'b1) begin
            errors++;
            $display("FAIL capture_digit%0d: got %h/%h/%b want %h/%h/1", k % 8, oAnode, oSeg, oValid,
                     ~(8'b1 << (k % 8)), seq[k % 8]);
         end
      end
   endtask

   task automatic test_ignore();
      iData = 32'hFFFFFFFF;
      repeat (32) begin
         @(negedge clk);
         checks++;
         if (oAnode !== expAnode() || oSeg !== expSeg() || oValid !== 1'b1 || $countones(~oAnode) != 1) begin
            errors++;
            $display("FAIL ignore_data: got %h/%h/%b want %h/%h/1", oAnode, oSeg, oValid, expAnode(), expSeg());
         end
      end
   endtask

   task automatic test_fall();
      iDone = 1'b0;
      @(negedge clk);
      checks++;
      if (oValid !== 1'b0 || oAnode !== 8'hFE || oSeg !== 8'hBF) begin
         errors++;
         $display("FAIL fall_first: got %h/%h/%b want FE/BF/0", oAnode, oSeg, oValid);
      end
      repeat (16) begin
         @(negedge clk);
         checks++;
         if (oAnode !== expAnode() || oSeg !== 8'hBF || oValid !== 1'b0) begin
            errors++;
            $display("FAIL fall_dashes: got %h/%h/%b want %h/BF/0", oAnode, oSeg, oValid, expAnode());
         end
      end
      iData = 32'h89EF4567; iDone = 1'b1;
      @(negedge clk);
      checks++;
      if (oSeg !== 8'hF8 || oAnode !== 8'hFE || oValid !== 1'b1) begin
         errors++;
         $display("FAIL recapture_d0: got %h/%h/%b want FE/F8/1", oAnode, oSeg, oValid);
      end
      repeat (7 * SCAN_DIV) @(negedge clk);
      checks++;
      if (oSeg !== 8'h80 || oAnode !== 8'h7F) begin
         errors++;
         $display("FAIL recapture_d7: got %h/%h want 7F/80", oAnode, oSeg);
      end
   endtask

   task automatic test_pulse();
      iDone = 1'b0;
      repeat (3) @(negedge clk);
      iData = $urandom; iDone = 1'b1;
      @(negedge clk);
      iDone = 1'b0;
      checks++;
      if (oValid !== 1'b1 || oSeg !== expSeg()) begin
         errors++;
         $display("FAIL pulse_high: got valid=%b seg=%h want 1 %h", oValid, oSeg, expSeg());
      end
      @(negedge clk);
      checks++;
      if (oValid !== 1'b0 || oSeg !== 8'hBF || oAnode !== 8'hFE) begin
         errors++;
         $display("FAIL pulse_low: got %h/%h/%b want FE/BF/0", oAnode, oSeg, oValid);
      end
   endtask

   task automatic test_random();
      repeat (600) begin
         if ($urandom_range(5) == 0) iDone = ~iDone;
         iData = $urandom;
         @(negedge clk);
         checks++;
         if (oAnode !== expAnode() || oSeg !== expSeg() || oValid !== mShow || $countones(~oAnode) != 1) begin
            errors++;
            $display("FAIL random: got %h/%h/%b want %h/%h/%b", oAnode, oSeg, oValid, expAnode(), expSeg(), mShow);
         end
      end
   endtask

   task automatic test_async_reset();
      iDone = 1'b0;
      @(negedge clk);
      iData = 32'hDEADBEEF; iDone = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if (oValid !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got valid=%b want 1", oValid);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (oAnode !== 8'hFF || oSeg !== 8'hFF || oValid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got %h/%h/%b want FF/FF/0", oAnode, oSeg, oValid);
      end
      @(negedge clk);
      rst = 1'b1;
      iDone = 1'b0;
      @(negedge clk);
      checks++;
      if (oAnode !== 8'hFE || oSeg !== 8'hBF || oValid !== 1'b0) begin
         errors++;
         $display("FAIL async_release: got %h/%h/%b want FE/BF/0", oAnode, oSeg, oValid);
      end
   endtask

   initial begin
      rst = 1'b0; iDone = 1'b0; iData = '0;
      test_reset();
      test_capture();
      test_ignore();
      test_fall();
      test_pulse();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
